// File: rtl/i2c_target.sv
// I2C target exposing a byte-wide register bank: 7-bit address, register pointer,
// auto-increment reads/writes and repeated START. SCL is never stretched.
module i2c_target #(
  parameter logic [6:0] DEVICE_ADDR = 7'h42,
  parameter int         NUM_REGS    = 16,
  parameter int         PTR_W       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_o,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] loc_addr,
  input  logic [7:0]       loc_wdata,
  input  logic             loc_we,
  output logic [7:0]       loc_rdata,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_index,
  output logic [7:0]       wr_data,
  output logic             active
);

  typedef enum logic [3:0] {
    StIdle, StRxAddr, StAckAddr, StRxPtr, StAckPtr,
    StRxData, StAckData, StTxByte, StRxMack, StIgnore
  } state_e;

  state_e             state;
  logic [1:0]         scl_sync, sda_sync;
  logic               scl_prev, sda_prev;
  logic               scl_cur, sda_cur;
  logic               scl_rise, scl_fall, start_ev, stop_ev;
  logic [2:0]         bit_cnt;
  logic [7:0]         shift;
  logic [7:0]         rx_byte;
  logic               rw;
  logic               ack_flag;
  logic [PTR_W-1:0]   ptr;
  logic [7:0]         regs [NUM_REGS];

  // Idle bus is high, so the synchronizers reset high to avoid phantom edges.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  assign scl_cur   = scl_sync[1];
  assign sda_cur   = sda_sync[1];
  assign scl_rise  = ~scl_prev & scl_cur;
  assign scl_fall  = scl_prev & ~scl_cur;
  assign start_ev  = scl_prev & scl_cur & sda_prev & ~sda_cur;
  assign stop_ev   = scl_prev & scl_cur & ~sda_prev & sda_cur;
  assign rx_byte   = {shift[6:0], sda_cur};
  assign sda_o     = 1'b0;
  assign loc_rdata = regs[loc_addr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= StIdle;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      rw        <= 1'b0;
      ack_flag  <= 1'b0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      active    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
      wr_data   <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      // Placed first so a same-cycle I2C commit to the same index overrides it.
      if (loc_we) regs[loc_addr] <= loc_wdata;

      if (start_ev) begin
        state    <= StRxAddr;
        bit_cnt  <= 3'd0;
        ack_flag <= 1'b0;
        sda_oe   <= 1'b0;
      end else if (stop_ev) begin
        state  <= StIdle;
        active <= 1'b0;
        sda_oe <= 1'b0;
      end else begin
        unique case (state)
          StIdle, StIgnore: sda_oe <= 1'b0;

          StRxAddr: if (scl_rise) begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rw       <= rx_byte[0];
              ack_flag <= 1'b0;
              if (rx_byte[7:1] == DEVICE_ADDR) begin
                state  <= StAckAddr;
                active <= 1'b1;
              end else begin
                state  <= StIgnore;
                active <= 1'b0;
              end
            end
          end

          // ack_flag marks that the ACK bit is already on the bus.
          StAckAddr: if (scl_fall) begin
            if (!ack_flag) begin
              sda_oe   <= 1'b1;
              ack_flag <= 1'b1;
            end else begin
              ack_flag <= 1'b0;
              bit_cnt  <= 3'd0;
              if (rw) begin
                shift  <= regs[ptr];
                sda_oe <= ~regs[ptr][7];
                state  <= StTxByte;
              end else begin
                sda_oe <= 1'b0;
                state  <= StRxPtr;
              end
            end
          end

          StRxPtr: if (scl_rise) begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr      <= rx_byte[PTR_W-1:0];
              ack_flag <= 1'b0;
              state    <= StAckPtr;
            end
          end

          StRxData: if (scl_rise) begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              regs[ptr] <= rx_byte;
              wr_strobe <= 1'b1;
              wr_index  <= ptr;
              wr_data   <= rx_byte;
              ptr       <= ptr + PTR_W'(1);
              ack_flag  <= 1'b0;
              state     <= StAckData;
            end
          end

          StAckPtr, StAckData: if (scl_fall) begin
            if (!ack_flag) begin
              sda_oe   <= 1'b1;
              ack_flag <= 1'b1;
            end else begin
              sda_oe   <= 1'b0;
              ack_flag <= 1'b0;
              bit_cnt  <= 3'd0;
              state    <= StRxData;
            end
          end

          StTxByte: if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe   <= 1'b0;
              ptr      <= ptr + PTR_W'(1);
              bit_cnt  <= 3'd0;
              ack_flag <= 1'b0;
              state    <= StRxMack;
            end else begin
              shift   <= {shift[6:0], 1'b0};
              sda_oe  <= ~shift[6];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end

          StRxMack: begin
            if (scl_rise) begin
              if (sda_cur) state <= StIgnore;
              else         ack_flag <= 1'b1;
            end else if (scl_fall && ack_flag) begin
              shift    <= regs[ptr];
              sda_oe   <= ~regs[ptr][7];
              bit_cnt  <= 3'd0;
              ack_flag <= 1'b0;
              state    <= StTxByte;
            end
          end

          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
